// File: rtl/param_fifo.sv
// ============================================================================
// Module   : param_fifo
// Brief    : Parameterised single-clock FIFO with a registered read port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module param_fifo #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 16,
    parameter logic [WIDTH-1:0] INIT_VALUE = WIDTH'(8'hAA)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned c_AW = $clog2(DEPTH);
    localparam int unsigned c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_acc;
    logic             w_rd_acc;

    assign w_full   = (r_count == c_CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    // Blocking on the flags gives the boundary rules for free: no
    // fall-through when empty, no write-through when full.
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    // Storage is deliberately left out of reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_out   <= INIT_VALUE;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_acc;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_rd_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_param_fifo.sv
// ============================================================================
// Module   : tb_param_fifo
// Brief    : Directed and scoreboard checks for param_fifo (WIDTH=8, DEPTH=16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_param_fifo;

    localparam int c_DEPTH = 16;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       full;
    logic       empty;
    logic [4:0] count;

    int         checks;
    int         errors;
    logic [7:0] q[$];
    logic [7:0] exp_out;

    param_fifo #(
        .WIDTH      (8),
        .DEPTH      (c_DEPTH),
        .INIT_VALUE (8'hAA)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic exp_dv);
        check({tag, "_out"},   data_out,   exp_out);
        check({tag, "_dv"},    data_valid, exp_dv);
        check({tag, "_count"}, count,      q.size());
        check({tag, "_empty"}, empty,      q.size() == 0);
        check({tag, "_full"},  full,       q.size() == c_DEPTH);
    endtask

    // Reset asserted with both requests active; they must be overridden.
    task automatic do_reset(input int cycles);
        rst     = 1'b0;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        data_in = 8'h33;
        repeat (cycles) @(posedge clk);
        #1;
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        q.delete();
        exp_out = 8'hAA;
        check_state("reset", 1'b0);
    endtask

    // One clock with the given requests; the queue is the reference model.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input string tag);
        logic wacc, racc;
        wacc    = w && (q.size() < c_DEPTH);
        racc    = r && (q.size() > 0);
        rst     = 1'b1;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        if (racc) exp_out = q.pop_front();
        if (wacc) q.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(tag, racc);
    endtask

    initial begin
        int nw, nr, guard;
        logic w, r;
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
        exp_out = 8'hAA;

        do_reset(2);

        // Fill, overfill, drain
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, "fill");
        check("fill_full", full, 1'b1);
        check("fill_count", count, 5'd16);
        cyc(1'b1, 8'hFF, 1'b0, "overfill");
        check("overfill_count", count, 5'd16);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, "drain");
            check("drain_word", data_out, 8'(i));
            check("drain_dv", data_valid, 1'b1);
        end
        check("drain_empty", empty, 1'b1);

        // Read on empty holds last word
        repeat (3) cyc(1'b0, 8'h00, 1'b1, "rd_empty");
        check("rd_empty_hold", data_out, 8'h0F);
        check("rd_empty_dv", data_valid, 1'b0);

        // Simultaneous at empty: write only
        cyc(1'b1, 8'h5A, 1'b1, "sim_empty");
        check("sim_empty_count", count, 5'd1);
        check("sim_empty_dv", data_valid, 1'b0);
        check("sim_empty_out", data_out, 8'h0F);

        // Simultaneous at full: read only
        for (int i = 1; i < 16; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, "refill");
        check("refill_full", full, 1'b1);
        cyc(1'b1, 8'h77, 1'b1, "sim_full");
        check("sim_full_count", count, 5'd15);
        check("sim_full_out", data_out, 8'h5A);
        while (q.size() > 0) cyc(1'b0, 8'h00, 1'b1, "drain2");
        check("drain2_last", data_out, 8'h6F);

        // Interleaved traffic across pointer wrap
        cyc(1'b1, 8'hC3, 1'b0, "wrap");
        nw = 1; nr = 0; guard = 0;
        while (nr < 40 && guard < 2000) begin
            w = (nw < 40) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 1) == 1);
            if (w && !r && q.size() >= 15) w = 1'b0;
            if (r && !w && q.size() <= 1 && nw < 40) r = 1'b0;
            if (w) nw++;
            if (r && q.size() > 0) nr++;
            cyc(w, 8'($urandom_range(0, 255)), r, "wrap");
            guard++;
        end
        check("wrap_done", nr, 40);
        check("wrap_empty", empty, 1'b1);

        // Mid-stream reset discards contents
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0, "pre_rst");
        check("pre_rst_count", count, 5'd7);
        do_reset(1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hE0 + i), 1'b0, "post_wr");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1, "post_rd");
            check("post_rd_word", data_out, 8'(8'hE0 + i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
